alu_selftest: RTL



---
 rtl/alu_selftest.sv | 86 ++++++++
 1 files changed

// File: rtl/alu_selftest.sv
// alu_selftest: ALU BIST walking nine R-type vectors; ports: clk/reset/start, ALUOut/Branch_Enable in, A/B/FuncCode/Opcode drive, busy/done/pass/fail_index/fail_value/fail_count report
module alu_selftest #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ALUOut,
  input  logic        Branch_Enable,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  FuncCode,
  output logic [6:0]  Opcode,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_index,
  output logic [31:0] fail_value,
  output logic [3:0]  fail_count
);
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  localparam logic [8:0][3:0] FUNC = {4'b0100, 4'b0001, 4'b1101, 4'b0101, 4'b0010,
                                      4'b1000, 4'b0000, 4'b0110, 4'b0111};
  localparam logic [8:0][31:0] OPA = {32'h55, 32'd2, 32'd8, 32'd16, 32'd0,
                                      32'd10000, 32'd10000, 32'h0F, 32'h0F};
  localparam logic [8:0][31:0] OPB = {32'hFF, 32'd2, 32'd1, 32'd2, 32'd2,
                                      32'd111, 32'd111, 32'h55, 32'h55};
  localparam logic [8:0][31:0] EXP = {32'hAA, 32'd8, 32'd4, 32'd4, 32'd1,
                                      32'd9889, 32'd10111, 32'h5F, 32'h05};
  state_t state, next_state;
  logic [3:0] idx, cnt, ld_idx;
  logic accept, load, mismatch, unused_ok;
  assign unused_ok = Branch_Enable;
  assign accept = (state == IDLE || state == DONE) && start;
  assign load = accept || (state == CHECK && idx != 4'd8);
  assign ld_idx = (state == CHECK) ? idx + 4'd1 : 4'd0;
  assign mismatch = ALUOut != EXP[idx];
  assign busy = state == APPLY || state == CHECK;
  assign done = state == DONE;
  assign pass = done && fail_count == 4'd0;
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: next_state = start ? APPLY : state;
      APPLY: next_state = (cnt == 4'(SETTLE_CYCLES - 1)) ? CHECK : APPLY;
      CHECK: next_state = (idx == 4'd8) ? DONE : APPLY;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      cnt <= '0;
      A <= '0;
      B <= '0;
      FuncCode <= '0;
      Opcode <= '0;
      fail_index <= '0;
      fail_value <= '0;
      fail_count <= '0;
    end else begin
      cnt <= (state == APPLY) ? cnt + 4'd1 : 4'd0;
      if (load) begin
        idx <= ld_idx;
        A <= OPA[ld_idx];
        B <= OPB[ld_idx];
        FuncCode <= FUNC[ld_idx];
        Opcode <= 7'b0110011;
      end
      if (accept) begin
        fail_index <= '0;
        fail_value <= '0;
        fail_count <= '0;
      end else if (state == CHECK && mismatch) begin
        fail_count <= (fail_count == 4'd15) ? fail_count : fail_count + 4'd1;
        if (fail_count == 4'd0) begin
          fail_index <= idx;
          fail_value <= ALUOut;
        end
      end
    end
  end
endmodule
